alu_cmd_issue: RTL and testbench

Upstream issue stage for the 8-bit ALU.
- Buffers operation commands in a small FIFO and drives the ALU's A, B and OP_SEL inputs from registers, one operation at a time.
- Captures the ALU's 9-bit Out_with_carry into a result register and presents it downstream with a valid/ready handshake.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_cmd_fifo.sv | 37 +++
 rtl/alu_cmd_issue.sv | 108 ++++++++++
 tb/tb_alu_cmd_issue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, default sizes and FSM state encodings for the ALU issue stage
package alu_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_OUT} state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: sync FIFO (push/din in, pop in, head/full/empty out), refuses push when full and pop when empty
module alu_cmd_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = mem_q[rp_q];
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    always_ff @(posedge clk)
        if (wr) mem_q[wp_q] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(rd);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
endmodule

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: queues cmd_* commands, drives A/B/OP_SEL to the ALU, captures Out_with_carry into res_* (valid/ready); ALU_ACC_FWD_EN enables accumulator forwarding via cmd_use_acc
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        OP_SEL,
    input  logic [DATA_W:0]   Out_with_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry
);
`ifdef ALU_ACC_FWD_EN
    localparam int EW = 2*DATA_W+4;
`else
    localparam int EW = 2*DATA_W+3;
`endif
    logic [EW-1:0]     cmd_e, head_e, ld_e;
    logic [DATA_W-1:0] ld_a, a_q, b_q, res_data_q;
    logic [2:0]        op_q;
    logic              full, empty, push, ld, res_valid_q, res_carry_q;
    state_t            state_q;
`ifdef ALU_ACC_FWD_EN
    logic [DATA_W-1:0] acc_q;
    assign cmd_e = {cmd_use_acc, cmd_op, cmd_b, cmd_a};
    assign ld_a  = ld_e[EW-1] ? acc_q : ld_e[DATA_W-1:0];
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign cmd_e = {cmd_op, cmd_b, cmd_a};
    assign ld_a  = ld_e[DATA_W-1:0];
`endif
    assign push      = cmd_valid && !full;
    assign cmd_ready = !full;
    assign ld_e      = empty ? cmd_e : head_e;
    assign ld = (state_q == ST_IDLE && !empty) ||
                (state_q == ST_OUT && res_ready && (!empty || push));
    assign A         = a_q;
    assign B         = b_q;
    assign OP_SEL    = op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    alu_cmd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (state_q == ST_EXEC),
        .din   (cmd_e),
        .head  (head_e),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_NOP;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
`ifdef ALU_ACC_FWD_EN
            acc_q       <= '0;
`endif
        end else begin
            if (ld) begin
                a_q  <= ld_a;
                b_q  <= ld_e[2*DATA_W-1:DATA_W];
                op_q <= ld_e[2*DATA_W+2:2*DATA_W];
            end
            case (state_q)
                ST_IDLE: begin
                    if (ld) state_q <= ST_EXEC;
                    else op_q <= OP_NOP;
                end
                ST_EXEC: begin
                    res_data_q  <= Out_with_carry[DATA_W-1:0];
                    res_carry_q <= Out_with_carry[DATA_W];
                    res_valid_q <= 1'b1;
`ifdef ALU_ACC_FWD_EN
                    acc_q       <= Out_with_carry[DATA_W-1:0];
`endif
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ld ? ST_EXEC : ST_IDLE;
                        if (!ld) op_q <= OP_NOP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: directed self-checking bench for alu_cmd_issue with a behavioural ALU
module tb_alu_cmd_issue;
    logic       clk, rst, cmd_valid, cmd_ready, cmd_use_acc, res_valid, res_ready, res_carry;
    logic [7:0] cmd_a, cmd_b, A, B, res_data;
    logic [2:0] cmd_op, OP_SEL;
    logic [8:0] Out_with_carry;
    int         pass_n = 0, total_n = 0, acc_n;

    alu_cmd_issue dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_op         (cmd_op),
        .cmd_use_acc    (cmd_use_acc),
        .A              (A),
        .B              (B),
        .OP_SEL         (OP_SEL),
        .Out_with_carry (Out_with_carry),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_carry      (res_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb
        Out_with_carry = OP_SEL == 3'b001 ? {1'b0, A} + {1'b0, B} :
                         OP_SEL == 3'b010 ? {1'b0, A} - {1'b0, B} :
                         OP_SEL == 3'b011 ? {1'b0, ~A} :
                         OP_SEL == 3'b100 ? {1'b0, A & B} :
                         OP_SEL == 3'b101 ? {1'b0, A | B} :
                         OP_SEL == 3'b110 ? {1'b0, A ^ B} : 9'h000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ua);
        cmd_valid   = v;
        cmd_a       = a;
        cmd_b       = b;
        cmd_op      = op;
        cmd_use_acc = ua;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] d, input logic c);
        chk({tag, "_valid"}, 16'(res_valid), 16'd1);
        chk({tag, "_data"},  16'(res_data),  16'(d));
        chk({tag, "_carry"}, 16'(res_carry), 16'(c));
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
        #2;
        chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        chk("rst_res_valid", 16'(res_valid), 16'd0);
        chk("rst_A", 16'(A), 16'd0);
        chk("rst_B", 16'(B), 16'd0);
        chk("rst_OP_SEL", 16'(OP_SEL), 16'd0);
        chk("rst_res", 16'({res_carry, res_data}), 16'd0);
        tick();
        rst = 1'b0;
        tick();

        // single add: ALU driven after N+1, result after N+2
        res_ready = 1'b1;
        drive(1'b1, 8'd10, 8'd20, 3'b001, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("t1_A_pre", 16'(A), 16'd0);
        tick();
        chk("t1_A", 16'(A), 16'd10);
        chk("t1_B", 16'(B), 16'd20);
        chk("t1_OP_SEL", 16'(OP_SEL), 16'd1);
        chk("t1_valid_pre", 16'(res_valid), 16'd0);
        tick();
        chk_res("t1", 8'd30, 1'b0);
        tick();
        chk("t1_done_valid", 16'(res_valid), 16'd0);
        chk("t1_done_op", 16'(OP_SEL), 16'd0);

        // back-to-back add with carry then sub
        drive(1'b1, 8'd200, 8'd100, 3'b001, 1'b0);
        tick();
        drive(1'b1, 8'd30, 8'd15, 3'b010, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_res("t2_r0", 8'd44, 1'b1);
        tick();
        chk("t2_gap_valid", 16'(res_valid), 16'd0);
        tick();
        chk_res("t2_r1", 8'd15, 1'b0);
        tick();
        tick();

        // capacity: DEPTH+1 accepted with res_ready low
        res_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(i + 1), 8'd1, 3'b001, 1'b0);
            chk($sformatf("t3_ready_%0d", i), 16'(cmd_ready), 16'(i < 5));
            if (cmd_ready) acc_n++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("t3_accepted", 16'(acc_n), 16'd5);
        tick();
        chk("t3_ready_held", 16'(cmd_ready), 16'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_res($sformatf("t3_r%0d", i), 8'(i + 2), 1'b0);
            tick();
            tick();
        end
        chk("t3_end_valid", 16'(res_valid), 16'd0);
        chk("t3_end_ready", 16'(cmd_ready), 16'd1);
        chk("t3_end_op", 16'(OP_SEL), 16'd0);

        // reset while OUT with three queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i + 50), 8'd3, 3'b001, 1'b0);
            tick();
        end
        cmd_valid = 1'b0;
        chk_res("t4_pre", 8'd53, 1'b0);
        rst = 1'b1;
        #1;
        chk("t4_valid", 16'(res_valid), 16'd0);
        chk("t4_ready", 16'(cmd_ready), 16'd1);
        chk("t4_A", 16'(A), 16'd0);
        chk("t4_B", 16'(B), 16'd0);
        chk("t4_op", 16'(OP_SEL), 16'd0);
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t4_stale_%0d", i), 16'({res_valid, OP_SEL}), 16'd0);
        end

        // logic ops
        drive(1'b1, 8'hCC, 8'hAA, 3'b100, 1'b0);
        tick();
        drive(1'b1, 8'hCC, 8'hAA, 3'b101, 1'b0);
        tick();
        drive(1'b1, 8'hCC, 8'hAA, 3'b110, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk_res("t5_and", 8'h88, 1'b0);
        tick();
        tick();
        chk_res("t5_or", 8'hEE, 1'b0);
        tick();
        tick();
        chk_res("t5_xor", 8'h66, 1'b0);
        tick();
        tick();

        // accumulator chaining (A from last result only with forwarding)
        drive(1'b1, 8'd10, 8'd20, 3'b001, 1'b0);
        tick();
        drive(1'b1, 8'd0, 8'd5, 3'b010, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_res("t6_r0", 8'd30, 1'b0);
        tick();
        tick();
`ifdef ALU_ACC_FWD_EN
        chk_res("t6_r1", 8'd25, 1'b0);
`else
        chk_res("t6_r1", 8'hFB, 1'b1);
`endif
        tick();
        tick();
        chk("t6_idle_valid", 16'(res_valid), 16'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
